// File: rtl/dp_pkg.sv
// Package: dp_pkg
// Shared declarations for the dp_mux_pipe datapath source multiplexer.
//   state_t   : skid buffer occupancy states (EMPTY, ONE, TWO)
//   lane_lsb  : bit offset of a lane inside a packed multi-lane bus
package dp_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_ONE   = 2'd1,  // main register valid
    ST_TWO   = 2'd2   // main and skid registers valid
  } state_t;

  // Lane k of a packed bus occupies bits [k*width +: width].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dp_mux_pipe_if.sv
// Interface: dp_mux_pipe_if
// Bundles the select/data/handshake signals of dp_mux_pipe.
//   sel       lane select, sampled only on accept
//   in_data   NUM_IN packed lanes of WIDTH bits
//   in_valid / in_ready    upstream handshake (accept = in_valid & in_ready)
//   out_data / out_valid / out_ready  downstream handshake (pop = out_valid & out_ready)
//   state     buffer occupancy, exported for observation
// Handshake rule on both sides: a word moves on a rising edge where valid and
// ready are both 1; the producer holds data stable while valid=1 and ready=0.
// Modports: master = the environment (upstream source + downstream sink),
//           slave  = the dp_mux_pipe block.
interface dp_mux_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  import dp_pkg::*;

  localparam int SEL_W = $clog2(NUM_IN);

  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  state_t                  state;

  modport master (
    output sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, state
  );

  modport slave (
    input  sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, state
  );

endinterface

// File: rtl/dp_skid_buf.sv
// Module: dp_skid_buf
// Two-entry valid/ready skid buffer with registered in_ready and out_valid.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push          producer offers push_data (qualified internally by in_ready)
//   push_data     word to enqueue
//   out_ready     consumer takes the head word
//   in_ready      registered: 1 unless both entries will be full
//   out_valid     registered: head word present
//   out_data      registered head word (main register)
//   state         occupancy state
module dp_skid_buf
  import dp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output state_t           state
);

  logic [WIDTH-1:0] skid_q;
  logic             acc;
  logic             pop;

  assign acc = push & in_ready;
  assign pop = out_valid & out_ready;

  // in_ready and out_valid are written alongside each state transition so they
  // always equal (state != ST_TWO) and (state != ST_EMPTY) without any
  // combinational path from the handshake inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            out_data  <= push_data;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && !pop) begin
            // Head is stalled: park the new word behind it.
            skid_q   <= push_data;
            in_ready <= 1'b0;
            state    <= ST_TWO;
          end else if (acc && pop) begin
            out_data <= push_data;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            out_data <= skid_q;
            skid_q   <= '0;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/dp_mux_pipe.sv
// Module: dp_mux_pipe
// Selects one of NUM_IN lanes of WIDTH bits and delivers it through a 2-entry
// skid buffer (one-cycle latency, independent upstream/downstream stalls).
// Parameters: WIDTH (lane width), NUM_IN (>= 2, any value); SEL_W derived.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            dp_mux_pipe_if.slave: sel, in_data, in_valid, in_ready,
//                  out_data, out_valid, out_ready, state
//   sel_err        sticky out-of-range select flag
//   sel_err_clr    synchronous clear of sel_err (set has priority)
// Build option DP_MUX_SELERR_EN:
//   defined   - an accepted word with sel >= NUM_IN is dropped and sel_err set
//   undefined - such a word is enqueued as all zeros; sel_err is tied 0
module dp_mux_pipe
  import dp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dp_mux_pipe_if.slave    bus,
  output logic            sel_err,
  input  logic            sel_err_clr
);

  localparam int SEL_W = $clog2(NUM_IN);

  logic [SEL_W-1:0] sel_w;
  logic [WIDTH-1:0] lane_word;
  logic             sel_ok;
  logic             push;
  logic             in_ready_w;
  logic             out_valid_w;
  logic [WIDTH-1:0] out_data_w;
  state_t           state_w;

  assign sel_w = bus.sel;

  // Out-of-range selects match no lane, leaving lane_word at zero.
  always_comb begin
    lane_word = '0;
    sel_ok    = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel_w) == k) begin
        lane_word = bus.in_data[lane_lsb(k, WIDTH) +: WIDTH];
        sel_ok    = 1'b1;
      end
    end
  end

`ifdef DP_MUX_SELERR_EN
  logic accept;

  assign accept = bus.in_valid & in_ready_w;
  // The handshake is still honoured for a bad select; only the enqueue is gated.
  assign push   = bus.in_valid & sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && !sel_ok) begin
      sel_err <= 1'b1;
    end else if (sel_err_clr) begin
      sel_err <= 1'b0;
    end
  end
`else
  logic unused_sel_err_clr;

  assign push               = bus.in_valid;
  assign sel_err            = 1'b0;
  assign unused_sel_err_clr = sel_err_clr | sel_ok;
`endif

  dp_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (lane_word),
    .out_ready (bus.out_ready),
    .in_ready  (in_ready_w),
    .out_valid (out_valid_w),
    .out_data  (out_data_w),
    .state     (state_w)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;
  assign bus.state     = state_w;

endmodule
